// File: rtl/nios2_pio_wrout_if.sv
// nios2_pio_wrout_if: Avalon-MM slave bus plus the out_port req/ack handshake
// of the nios2 output PIO, grouped so the block takes a single bus port.
// slave  : the PIO side (drives readdata, out_port, out_req).
// master : the CPU/fabric side (drives the Avalon strobes and out_ack).
interface nios2_pio_wrout_if #(
    parameter int DATA_WIDTH = 16
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_req;
    logic                  out_ack;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ack,
        output readdata, out_port, out_req
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ack,
        input  readdata, out_port, out_req
    );
endinterface

// File: rtl/nios2_pio_wrout.sv
// nios2_pio_wrout: Avalon-MM output PIO. Software writes DATA / OUTSET /
// OUTCLEAR; each update is offered on out_port with a four-phase out_req /
// out_ack handshake so the fabric takes it exactly once. STATUS reports
// busy, ack timeout and overrun (update while a handshake was in flight).
// Build option: define PIO_WROUT_ACK_SYNC_EN to pass out_ack through a
// 2-flop synchronizer when the fabric runs on another clock.
module nios2_pio_wrout #(
    parameter int          DATA_WIDTH  = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    nios2_pio_wrout_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];
    // Counter only has to reach ACK_TIMEOUT-1.
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_out_port;
    logic                  r_out_req;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic                  r_timeout;
    logic                  r_overrun;
    logic [31:0]           r_readdata;

    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_out_port_nxt;
    logic                  w_out_req_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_launch;
    logic                  w_tmo_set;
    logic                  w_tmo_hit;
    logic                  w_ack_s;
    logic                  w_wr;
    logic                  w_upd;
    logic                  w_stat_wr;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_unused;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_upd     = w_wr & (bus.address != 2'd1);
    assign w_stat_wr = w_wr & (bus.address == 2'd1);
    assign w_busy    = (r_state != S_IDLE);
    assign w_wdata   = bus.writedata[DATA_WIDTH-1:0];
    // Upper writedata bits are don't-care for narrow builds.
    assign w_unused  = ^bus.writedata;

`ifdef PIO_WROUT_ACK_SYNC_EN
    logic [1:0] r_ack_sync;

    // Two-flop synchronizer for an ack coming from another clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ack_sync <= 2'b00;
        else          r_ack_sync <= {r_ack_sync[0], bus.out_ack};
    end

    assign w_ack_s = r_ack_sync[1];
`else
    assign w_ack_s = bus.out_ack;
`endif

    if (ACK_TIMEOUT != 0) begin : g_tmo
        assign w_tmo_hit = (r_cnt == CNT_LAST);
    end else begin : g_no_tmo
        assign w_tmo_hit = 1'b0;
    end

    // New data register value for this cycle's write (DATA / OUTSET / OUTCLEAR).
    always_comb begin
        w_data_nxt = r_data;
        if (w_upd) begin
            case (bus.address)
                2'd0:    w_data_nxt = w_wdata;
                2'd2:    w_data_nxt = r_data | w_wdata;
                2'd3:    w_data_nxt = r_data & ~w_wdata;
                default: w_data_nxt = r_data;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_upd || r_pending) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_ack_s)        w_state_nxt = S_WAIT_LOW;
                else if (w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_WAIT_LOW: if (!w_ack_s) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: launch values, request drop, timeout counter and abort.
    always_comb begin
        w_out_port_nxt = r_out_port;
        w_out_req_nxt  = r_out_req;
        w_cnt_nxt      = r_cnt;
        w_launch       = 1'b0;
        w_tmo_set      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_upd || r_pending) begin
                    w_out_port_nxt = w_data_nxt;
                    w_out_req_nxt  = 1'b1;
                    w_cnt_nxt      = '0;
                    w_launch       = 1'b1;
                end
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_out_req_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_tmo_hit) begin
                        w_out_req_nxt = 1'b0;
                        w_tmo_set     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and status registers; set events win over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RST_DATA;
            r_out_port <= RST_DATA;
            r_out_req  <= 1'b0;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_data     <= w_data_nxt;
            r_out_port <= w_out_port_nxt;
            r_out_req  <= w_out_req_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_launch)            r_pending <= 1'b0;
            else if (w_upd && w_busy) r_pending <= 1'b1;
            r_timeout <= w_tmo_set | (r_timeout & ~(w_stat_wr & bus.writedata[1]));
            r_overrun <= (w_upd & w_busy) | (r_overrun & ~(w_stat_wr & bus.writedata[2]));
        end
    end

    // Registered read port: address sampled every cycle, no read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0;
        end else begin
            case (bus.address)
                2'd0:    r_readdata <= 32'(r_data);
                2'd1:    r_readdata <= {29'h0, r_overrun, r_timeout, w_busy};
                default: r_readdata <= 32'h0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.out_port = r_out_port;
    assign bus.out_req  = r_out_req;

endmodule

// File: tb/tb_nios2_pio_wrout.sv
// Bench for nios2_pio_wrout: a fabric model acks each request, a scoreboard
// queue holds the values expected on out_port in launch order, and a monitor
// pops/compares on each out_req rise and checks out_port stays stable.
module tb_nios2_pio_wrout;

    localparam int          DW  = 16;
    localparam logic [31:0] RV  = 32'h0;
    localparam int          TMO = 8;
`ifdef PIO_WROUT_ACK_SYNC_EN
    localparam int ACK_LAT = 6;
`else
    localparam int ACK_LAT = 4;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ack_en  = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    logic [DW-1:0] exp_q[$];

    nios2_pio_wrout_if #(.DATA_WIDTH(DW)) bus();

    nios2_pio_wrout #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(RV),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Fabric: ack 3 cycles after seeing out_req, drop it 2 cycles later.
    initial begin
        bus.out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && bus.out_req) begin
                repeat (3) @(negedge clk);
                bus.out_ack = 1'b1;
                repeat (2) @(negedge clk);
                bus.out_ack = 1'b0;
            end
        end
    end

    // Monitor: pop the scoreboard on each launch, check hold while requested.
    initial begin
        logic          prev_req;
        logic [DW-1:0] cur;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (bus.out_req && !prev_req) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL launch: out_port=%h offered, scoreboard empty", bus.out_port);
                end else begin
                    cur = exp_q.pop_front();
                    if (bus.out_port !== cur)
                        $display("FAIL launch: out_port=%h, expected %h", bus.out_port, cur);
                    else n_pass++;
                end
            end else if (bus.out_req && prev_req) begin
                n_chk++;
                if (bus.out_port !== cur)
                    $display("FAIL hold: out_port=%h changed during handshake, expected %h", bus.out_port, cur);
                else n_pass++;
            end
            prev_req = bus.out_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        bus.address = a;
        @(posedge clk); #1;
        q = bus.readdata;
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL %s drain: %0d launches missing, expected 0", tag, exp_q.size());
        else n_pass++;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n = 0;
        do begin
            rd(2'd1, s);
            n++;
        end while (s[0] && n < 60);
        n_chk++;
        if (s[0] !== 1'b0) $display("FAIL %s idle: status=%h, expected busy=0", tag, s);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk32("rst out_req", 32'(bus.out_req), 32'h0);
        chk32("rst out_port", 32'(bus.out_port), RV);
        chk32("rst readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(2'd0, q); chk32("rst data", q, 32'h0000);
        rd(2'd1, q); chk32("rst status", q, 32'h0);
    endtask

    task automatic test_write_handshake();
        logic [31:0] q;
        int n = 0;
        ack_en = 1'b1;
        exp_q.push_back(16'h1234);
        wr(2'd0, 32'h1234);
        chk32("hs out_req", 32'(bus.out_req), 32'h1);
        chk32("hs out_port", 32'(bus.out_port), 32'h1234);
        while (bus.out_req && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk32("hs req cycles", n, ACK_LAT);
        rd(2'd1, q); chk32("hs busy", q, 32'h1);
        repeat (4) @(posedge clk); #1;
        rd(2'd1, q); chk32("hs status end", q, 32'h0);
    endtask

    task automatic test_set_clear();
        logic [31:0] q;
        exp_q.push_back(16'h00F0);
        wr(2'd0, 32'h00F0);
        wait_drain("sc f0"); wait_idle("sc f0");
        exp_q.push_back(16'h00FF);
        wr(2'd2, 32'h000F);
        wait_drain("sc set"); wait_idle("sc set");
        exp_q.push_back(16'h00CF);
        wr(2'd3, 32'h0030);
        wait_drain("sc clr"); wait_idle("sc clr");
        rd(2'd0, q); chk32("sc data", q, 32'h00CF);
        rd(2'd2, q); chk32("sc read outset", q, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] q;
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h5555);
        wr(2'd0, 32'hAAAA);
        chk32("ovr first", 32'(bus.out_port), 32'hAAAA);
        wr(2'd0, 32'h5555);
        chk32("ovr hold", 32'(bus.out_port), 32'hAAAA);
        wait_drain("ovr"); wait_idle("ovr");
        rd(2'd1, q); chk32("ovr status", q, 32'h4);
        wr(2'd1, 32'h4);
        rd(2'd1, q); chk32("ovr w1c", q, 32'h0);
        rd(2'd0, q); chk32("ovr data", q, 32'h5555);
    endtask

    task automatic test_timeout();
        logic [31:0] q;
        int n = 0;
        ack_en = 1'b0;
        exp_q.push_back(16'h0001);
        wr(2'd0, 32'h0001);
        while (bus.out_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk32("tmo req cycles", n, TMO);
        rd(2'd1, q); chk32("tmo status", q, 32'h2);
        wr(2'd1, 32'h2);
        rd(2'd1, q); chk32("tmo w1c", q, 32'h0);
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic seen = 1'b0;
        ack_en = 1'b0;
        exp_q.push_back(16'h7777);
        wr(2'd0, 32'h7777);
        repeat (2) @(posedge clk); #1;
        chk32("rmid in req", 32'(bus.out_req), 32'h1);
        reset_n = 1'b0;
        #1;
        chk32("rmid out_req", 32'(bus.out_req), 32'h0);
        chk32("rmid out_port", 32'(bus.out_port), RV);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ack_en  = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_req) seen = 1'b1;
        end
        chk32("rmid no relaunch", 32'(seen), 32'h0);
        rd(2'd0, q); chk32("rmid data", q, RV);
        rd(2'd1, q); chk32("rmid status", q, 32'h0);
    endtask

    initial begin
        test_reset();
        test_write_handshake();
        test_set_clear();
        test_overrun();
        test_timeout();
        test_reset_mid();
        chk32("scoreboard empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
